vdic_dut_2022: RTL and testbench

- Serial-in/serial-out 8-bit multi-operand ALU.
- Receives a frame of 2..9 data bytes plus one command byte as 10-bit words on one serial line, gated by active-low enable_n.
- Returns a 3-word response (status, result high byte, result low byte) on a serial output with a valid strobe.
- Sits between a serial host link and nothing else; self-contained.

---
 rtl/vdic_dut_2022_if.sv | 14 +
 rtl/vdic_dut_2022.sv | 157 +++++++++++++++
 tb/tb_vdic_dut_2022.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/vdic_dut_2022_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vdic_dut_2022_if : serial host link of the multi-operand ALU      Rev 1.0
// ---------------------------------------------------------------------------
interface vdic_dut_2022_if;
  logic enable_n;
  logic din;
  logic dout;
  logic dout_valid;

  modport master (output enable_n, din, input dout, dout_valid);
  modport slave  (input enable_n, din, output dout, dout_valid);
endinterface
`default_nettype wire

// File: rtl/vdic_dut_2022.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vdic_dut_2022 : serial-in/serial-out 8-bit multi-operand ALU      Rev 1.0
// ---------------------------------------------------------------------------
module vdic_dut_2022 #(
  parameter int MIN_ARGS = 2,
  parameter int MAX_ARGS = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  vdic_dut_2022_if.slave  bus
);
  localparam int CW = $clog2(MAX_ARGS + 2);
  localparam logic [7:0] c_OP_NOP = 8'h00;
  localparam logic [7:0] c_OP_AND = 8'h01;
  localparam logic [7:0] c_OP_OR  = 8'h02;
  localparam logic [7:0] c_OP_XOR = 8'h03;
  localparam logic [7:0] c_OP_ADD = 8'h10;
  localparam logic [7:0] c_OP_SUB = 8'h20;

  typedef enum logic [1:0] {S_IDLE, S_RX_DATA, S_CALC, S_TX} state_t;

  state_t          r_state, w_state_nxt;
  logic [8:0]      r_sh;
  logic [3:0]      r_bit_cnt;
  logic [CW-1:0]   r_arg_cnt;
  logic            r_par_err;
  logic [7:0]      r_cmd;
  logic [7:0]      r_args [MAX_ARGS];
  logic [29:0]     r_tx_sr;
  logic [4:0]      r_tx_cnt;
  logic            r_dout, r_dout_valid;

  logic [9:0]      w_word;
  logic            w_word_done;
  logic [7:0]      w_and, w_or, w_xor;
  logic [15:0]     w_sum, w_diff, w_result;
  logic            w_bad_op, w_cnt_err;
  logic [7:0]      w_status;

  assign w_word      = {r_sh, bus.din};
  assign w_word_done = (r_bit_cnt == 4'd9);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:    if (!bus.enable_n) w_state_nxt = S_RX_DATA;
      S_RX_DATA: if (bus.enable_n) w_state_nxt = S_IDLE;
                 else if (w_word_done && w_word[9]) w_state_nxt = S_CALC;
      S_CALC:    w_state_nxt = S_TX;
      S_TX:      if (r_tx_cnt == 5'd30) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Reductions run only over the arguments actually received.
  always_comb begin
    w_and  = 8'hFF;
    w_or   = 8'h00;
    w_xor  = 8'h00;
    w_sum  = 16'h0000;
    w_diff = 16'h0000;
    for (int i = 0; i < MAX_ARGS; i++) begin
      if (CW'(i) < r_arg_cnt) begin
        w_and  = w_and & r_args[i];
        w_or   = w_or  | r_args[i];
        w_xor  = w_xor ^ r_args[i];
        w_sum  = w_sum + {8'h00, r_args[i]};
        w_diff = (i == 0) ? {8'h00, r_args[i]} : w_diff - {8'h00, r_args[i]};
      end
    end
  end

  always_comb begin
    w_bad_op  = 1'b0;
    w_result  = 16'h0000;
    w_cnt_err = (r_arg_cnt < CW'(MIN_ARGS)) || (r_arg_cnt > CW'(MAX_ARGS));
    case (r_cmd)
      c_OP_NOP: w_result = 16'h0000;
      c_OP_AND: w_result = {8'h00, w_and};
      c_OP_OR:  w_result = {8'h00, w_or};
      c_OP_XOR: w_result = {8'h00, w_xor};
      c_OP_ADD: w_result = w_sum;
      c_OP_SUB: w_result = w_diff;
      default:  w_bad_op = 1'b1;
    endcase
    w_status = {5'b00000, w_cnt_err, r_par_err, w_bad_op};
    if (w_status != 8'h00) w_result = 16'h0000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh         <= '0;
      r_bit_cnt    <= '0;
      r_arg_cnt    <= '0;
      r_par_err    <= 1'b0;
      r_cmd        <= '0;
      r_tx_sr      <= '0;
      r_tx_cnt     <= '0;
      r_dout       <= 1'b0;
      r_dout_valid <= 1'b0;
      for (int i = 0; i < MAX_ARGS; i++) r_args[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (!bus.enable_n) begin
          r_sh      <= {8'h00, bus.din};
          r_bit_cnt <= 4'd1;
          r_arg_cnt <= '0;
          r_par_err <= 1'b0;
        end
        S_RX_DATA: if (!bus.enable_n) begin
          r_sh <= w_word[8:0];
          if (w_word_done) begin
            r_bit_cnt <= 4'd0;
            if (^w_word) r_par_err <= 1'b1;
            if (w_word[9]) begin
              r_cmd <= w_word[8:1];
            end else begin
              if (r_arg_cnt < CW'(MAX_ARGS)) r_args[r_arg_cnt] <= w_word[8:1];
              // Saturate one past MAX_ARGS so an overlong frame stays flagged.
              if (r_arg_cnt <= CW'(MAX_ARGS)) r_arg_cnt <= r_arg_cnt + CW'(1);
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + 4'd1;
          end
        end
        S_CALC: begin
          r_tx_sr  <= {1'b1, w_status,        ^{1'b1, w_status},
                       1'b0, w_result[15:8],  ^w_result[15:8],
                       1'b0, w_result[7:0],   ^w_result[7:0]};
          r_tx_cnt <= 5'd0;
        end
        S_TX: begin
          if (r_tx_cnt == 5'd30) begin
            r_dout       <= 1'b0;
            r_dout_valid <= 1'b0;
          end else begin
            r_dout       <= r_tx_sr[29];
            r_tx_sr      <= {r_tx_sr[28:0], 1'b0};
            r_dout_valid <= 1'b1;
            r_tx_cnt     <= r_tx_cnt + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dout_valid;
endmodule
`default_nettype wire

// File: tb/tb_vdic_dut_2022.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_vdic_dut_2022 : directed-vector bench for the serial ALU       Rev 1.0
// ---------------------------------------------------------------------------
module tb_vdic_dut_2022;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  logic [7:0] args [10];

  vdic_dut_2022_if bus ();

  vdic_dut_2022 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [9:0] mk(input logic t, input logic [7:0] b);
    return {t, b, ^{t, b}};
  endfunction

  task automatic send_word(input logic t, input logic [7:0] b, input logic bad);
    logic [9:0] w;
    w = mk(t, b);
    if (bad) w[0] = ~w[0];
    for (int i = 9; i >= 0; i--) begin
      @(negedge clk);
      bus.enable_n = 1'b0;
      bus.din      = w[i];
    end
  endtask

  task automatic send_frame(input int n, input logic [7:0] op, input int bad_idx);
    for (int i = 0; i < n; i++) send_word(1'b0, args[i], i == bad_idx);
    send_word(1'b1, op, 1'b0);
  endtask

  task automatic get_resp(input string tag, input logic [7:0] est, input logic [15:0] eres);
    int lat;
    int width;
    logic [29:0] got;
    lat = 0;
    do begin
      @(negedge clk);
      bus.enable_n = 1'b1;
      bus.din      = 1'b0;
      lat++;
    end while (!bus.dout_valid && lat < 40);
    check({tag, "_latency"}, lat, 3);
    got[29] = bus.dout;
    width   = 1;
    for (int b = 28; b >= 0; b--) begin
      @(negedge clk);
      got[b] = bus.dout;
      if (bus.dout_valid) width++;
    end
    @(negedge clk);
    check({tag, "_valid_width"}, width, 30);
    check({tag, "_valid_fall"}, bus.dout_valid, 1'b0);
    check({tag, "_dout_idle"}, bus.dout, 1'b0);
    check({tag, "_status"}, got[29:20], mk(1'b1, est));
    check({tag, "_res_hi"}, got[19:10], mk(1'b0, eres[15:8]));
    check({tag, "_res_lo"}, got[9:0], mk(1'b0, eres[7:0]));
  endtask

  initial begin
    int seen;
    bus.enable_n = 1'b1;
    bus.din      = 1'b0;
    args = '{default: 8'h00};
    repeat (3) @(negedge clk);
    check("rst_dout", bus.dout, 1'b0);
    check("rst_valid", bus.dout_valid, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    args = '{default: 8'hFF};
    send_frame(9, 8'h10, -1);  get_resp("add9", 8'h00, 16'h08F7);

    args[0] = 8'h00; args[1] = 8'h01;
    send_frame(2, 8'h20, -1);  get_resp("sub", 8'h00, 16'hFFFF);

    args[0] = 8'hFF; args[1] = 8'h0F; args[2] = 8'hF3;
    send_frame(3, 8'h01, -1);  get_resp("and", 8'h00, 16'h0003);

    args[0] = 8'hFF; args[1] = 8'hFF;
    send_frame(2, 8'h03, -1);  get_resp("xor", 8'h00, 16'h0000);

    args[0] = 8'h00; args[1] = 8'h80;
    send_frame(2, 8'h02, -1);  get_resp("or", 8'h00, 16'h0080);

    args[0] = 8'h12; args[1] = 8'h34;
    send_frame(2, 8'h55, -1);  get_resp("badop", 8'h01, 16'h0000);

    args[0] = 8'h07;
    send_frame(1, 8'h10, -1);  get_resp("onearg", 8'h04, 16'h0000);

    args[0] = 8'h01; args[1] = 8'h02;
    send_frame(2, 8'h10, 1);   get_resp("parity", 8'h02, 16'h0000);

    args[0] = 8'h01; args[1] = 8'h02;
    send_frame(2, 8'h10, -1);  get_resp("add2", 8'h00, 16'h0003);

    args = '{default: 8'h01};
    send_frame(10, 8'h10, -1); get_resp("tenargs", 8'h04, 16'h0000);

    args[0] = 8'h05;
    send_frame(1, 8'h77, -1);  get_resp("multi", 8'h05, 16'h0000);

    // Abandoned frame must produce no response.
    args[0] = 8'h11; args[1] = 8'h22; args[2] = 8'h33;
    for (int i = 0; i < 3; i++) send_word(1'b0, args[i], 1'b0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      bus.enable_n = 1'b1;
      if (bus.dout_valid) seen++;
    end
    check("abort_no_resp", seen, 0);
    args[0] = 8'hAA; args[1] = 8'h55;
    send_frame(2, 8'h00, -1);  get_resp("nop", 8'h00, 16'h0000);

    // Asynchronous reset in the middle of a response.
    args[0] = 8'h10; args[1] = 8'h20;
    send_frame(2, 8'h10, -1);
    seen = 0;
    while (!bus.dout_valid && seen < 40) begin
      @(negedge clk);
      bus.enable_n = 1'b1;
      seen++;
    end
    check("pre_rst_valid", bus.dout_valid, 1'b1);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", bus.dout_valid, 1'b0);
    check("midrst_dout", bus.dout, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    args[0] = 8'h10; args[1] = 8'h20;
    send_frame(2, 8'h20, -1);  get_resp("post_rst_sub", 8'h00, 16'hFFF0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
